// File: rtl/bit_serial_serializer.sv
// -----------------------------------------------------------------------------
// bit_serial_serializer
//
// Upstream feeder for the bit-serial increment/decrement adder. Parallel
// two's-complement words arrive through a valid/ready handshake and are shifted
// out LSB-first, one bit per clock. Each frame carries its own sign_ctrl and
// a frame_start strobe on the bit-0 cycle. A one-word holding register (HR)
// lets consecutive words stream back to back with no gap cycles.
//
// Parameters:
//   WIDTH  bits per word, and serial frame length in cycles
//   CNT_W  bit-counter width, must equal log2(WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     in_data/in_sign are valid this cycle
//   in_ready     block can accept a word this cycle (registered decode)
//   in_data      parallel word to serialize
//   in_sign      sign_ctrl for this word: 1 = +1, 0 = -1 (all-ones add)
//   serial_out   current serial bit, LSB first (0 while idle)
//   sign_ctrl    sign control for the frame in flight, held while idle
//   frame_start  high during the cycle carrying bit 0 of a frame
//   out_valid    serial_out carries a data bit this cycle
//
// The downstream adder's frame counter must be aligned so its count-0 cycle
// coincides with frame_start; that alignment belongs to the integrator.
// -----------------------------------------------------------------------------
module bit_serial_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sign,
    output logic             serial_out,
    output logic             sign_ctrl,
    output logic             frame_start,
    output logic             out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Registered state
    state_t             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hr_data_q;
    logic               hr_sign_q;
    logic               hr_full_q;

    // Next-state values
    state_t             state_d;
    logic [WIDTH-1:0]   sr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   hr_data_d;
    logic               hr_sign_d;
    logic               hr_full_d;
    logic               sign_ctrl_d;
    logic               serial_out_d;
    logic               frame_start_d;
    logic               out_valid_d;

    logic               accept;
    logic               load_point;

    // in_ready depends only on a register, so there is no combinational path
    // from in_valid back to in_ready.
    assign in_ready   = ~hr_full_q;
    assign accept     = in_valid & ~hr_full_q;
    assign load_point = (state_q == IDLE) || (cnt_q == LAST_BIT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hr_data_d = hr_data_q;
        hr_sign_d = hr_sign_q;
        hr_full_d = hr_full_q;
        sign_ctrl_d = sign_ctrl;

        if (load_point) begin
            if (hr_full_q) begin
                // HR has priority over a word arriving at the same edge.
                sr_d        = hr_data_q;
                sign_ctrl_d = hr_sign_q;
                cnt_d       = '0;
                state_d     = SHIFT;
                // Refill HR if a word arrives at the same edge; otherwise it
                // drains. While in_ready mirrors ~hr_full this accept is
                // always 0, but the rule stays complete if that ever changes.
                hr_full_d   = accept;
                if (accept) begin
                    hr_data_d = in_data;
                    hr_sign_d = in_sign;
                end
            end else if (accept) begin
                // Bypass: the word accepted at this edge goes straight to SR.
                sr_d        = in_data;
                sign_ctrl_d = in_sign;
                cnt_d       = '0;
                state_d     = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end else begin
            // Mid-frame: shift towards bit 0. cnt only wraps through a load.
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (accept) begin
                hr_data_d = in_data;
                hr_sign_d = in_sign;
                hr_full_d = 1'b1;
            end
        end

        // Outputs are computed from next state and registered with it.
        out_valid_d   = (state_d == SHIFT);
        frame_start_d = (state_d == SHIFT) && (cnt_d == '0);
        serial_out_d  = (state_d == SHIFT) && sr_d[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // The holding register is cleared too so a discarded word can
            // never reappear after reset is released.
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            hr_data_q   <= '0;
            hr_sign_q   <= 1'b0;
            hr_full_q   <= 1'b0;
            sign_ctrl   <= 1'b0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hr_data_q   <= hr_data_d;
            hr_sign_q   <= hr_sign_d;
            hr_full_q   <= hr_full_d;
            sign_ctrl   <= sign_ctrl_d;
            serial_out  <= serial_out_d;
            frame_start <= frame_start_d;
            out_valid   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_bit_serial_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_serializer
//
// Directed bench for bit_serial_serializer. A queue-based model of the word
// stream predicts every output cycle by cycle; a monitor deserializes the DUT
// output so whole words, signs and frame_start timing can be compared against
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_bit_serial_serializer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sign;
    logic             serial_out;
    logic             sign_ctrl;
    logic             frame_start;
    logic             out_valid;

    bit_serial_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sign    (in_sign),
        .serial_out (serial_out),
        .sign_ctrl  (sign_ctrl),
        .frame_start(frame_start),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle counter: after edge k, cyc == k until the next edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- Behavioural model ----------------
    // Words waiting (at most one) sit in m_wait; the frame in flight is
    // m_cur, with m_idx the bit currently on the wire.
    logic [WIDTH-1:0] m_wait_data[$];
    logic             m_wait_sign[$];
    logic [WIDTH-1:0] m_cur;
    logic             m_sign;
    bit               m_active;
    int               m_idx;
    bit               m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wait_data.delete();
            m_wait_sign.delete();
            m_cur    = '0;
            m_sign   = 1'b0;
            m_active = 1'b0;
            m_idx    = 0;
        end else begin
            m_acc = in_valid && (m_wait_data.size() == 0);
            if (m_acc) begin
                m_wait_data.push_back(in_data);
                m_wait_sign.push_back(in_sign);
            end
            if (!m_active || m_idx == WIDTH - 1) begin
                if (m_wait_data.size() > 0) begin
                    m_cur    = m_wait_data.pop_front();
                    m_sign   = m_wait_sign.pop_front();
                    m_idx    = 0;
                    m_active = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_idx++;
            end
        end
    end

    // Per-cycle compare: {out_valid, frame_start, serial_out, sign_ctrl, in_ready}
    logic [4:0] exp_vec;
    always @(negedge clk) begin
        if (!reset) begin
            exp_vec = {m_active, m_active && (m_idx == 0),
                       m_active ? m_cur[m_idx] : 1'b0, m_sign,
                       m_wait_data.size() == 0};
            check("cycle_outputs", {59'd0, out_valid, frame_start, serial_out, sign_ctrl, in_ready},
                  {59'd0, exp_vec});
        end
    end

    // ---------------- Monitor / deserializer ----------------
    int               valid_cnt = 0;
    int               fs_cyc[$];
    logic [WIDTH-1:0] rx_data[$];
    logic             rx_sign[$];
    logic [WIDTH-1:0] shreg;
    int               bitpos = 0;

    always @(negedge clk) begin
        if (reset) begin
            bitpos = 0;
        end else if (out_valid) begin
            valid_cnt++;
            if (frame_start) begin
                fs_cyc.push_back(cyc);
                bitpos = 0;
                shreg  = '0;
            end
            shreg[bitpos] = serial_out;
            bitpos++;
            if (bitpos == WIDTH) begin
                rx_data.push_back(shreg);
                rx_sign.push_back(sign_ctrl);
                bitpos = 0;
            end
        end
    end

    task automatic clear_mon();
        valid_cnt = 0;
        fs_cyc.delete();
        rx_data.delete();
        rx_sign.delete();
    endtask

    // Present a word at the current negedge and hold it until accepted.
    // Returns at the negedge after the accepting edge with in_valid still high;
    // acc is cyc at that point (the accepting edge number).
    task automatic send(input logic [WIDTH-1:0] d, input logic s, output int acc);
        bit done;
        done     = 1'b0;
        acc      = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_sign  = s;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc  = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    int ka, kb, kc, kd;
    int gap_wait;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sign  = 1'b0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("reset_outputs", {59'd0, out_valid, frame_start, serial_out, sign_ctrl, in_ready},
              64'b00001);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---- Single word in IDLE ----
        clear_mon();
        send(32'h0000_0005, 1'b1, ka);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("single_valid_cycles", valid_cnt, 32);
        check("single_fs_count", fs_cyc.size(), 1);
        if (fs_cyc.size() >= 1) check("single_fs_latency", fs_cyc[0], ka);
        check("single_rx_count", rx_data.size(), 1);
        if (rx_data.size() >= 1) begin
            check("single_rx_data", rx_data[0], 64'h5);
            check("single_rx_sign", rx_sign[0], 1);
        end

        // ---- Back-to-back with backpressure ----
        clear_mon();
        send(32'hFFFF_FFFF, 1'b0, ka);
        send(32'h8000_0001, 1'b1, kb);
        send(32'h1234_5678, 1'b0, kc);
        in_valid = 1'b0;
        check("b2b_hr_accept", kb, ka + 1);
        // HR full until the load edge ending frame 1; accepted one edge later.
        check("b2b_stall_accept", kc, ka + 33);
        repeat (80) @(negedge clk);
        check("b2b_valid_cycles", valid_cnt, 96);
        check("b2b_fs_count", fs_cyc.size(), 3);
        if (fs_cyc.size() == 3) begin
            check("b2b_fs0", fs_cyc[0], ka);
            check("b2b_fs1", fs_cyc[1], ka + 32);
            check("b2b_fs2", fs_cyc[2], ka + 64);
        end
        check("b2b_rx_count", rx_data.size(), 3);
        if (rx_data.size() == 3) begin
            check("b2b_rx0", rx_data[0], 64'hFFFF_FFFF);
            check("b2b_rx1", rx_data[1], 64'h8000_0001);
            check("b2b_rx2", rx_data[2], 64'h1234_5678);
            check("b2b_signs", {rx_sign[0], rx_sign[1], rx_sign[2]}, 64'b010);
        end

        // ---- Idle gap ----
        clear_mon();
        send(32'hC3C3_0F0F, 1'b1, ka);
        in_valid = 1'b0;
        gap_wait = 0;
        while (out_valid && gap_wait < 100) begin
            @(negedge clk);
            gap_wait++;
        end
        if (gap_wait >= 100) check("gap_drain_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("gap_idle", {62'd0, out_valid, serial_out}, 64'd0);
            @(negedge clk);
        end
        clear_mon();
        send(32'h0000_00A0, 1'b0, kd);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("gap_fs_count", fs_cyc.size(), 1);
        if (fs_cyc.size() >= 1) check("gap_fs_latency", fs_cyc[0], kd);
        repeat (40) @(negedge clk);
        check("gap_rx_count", rx_data.size(), 1);
        if (rx_data.size() >= 1) check("gap_rx_data", rx_data[0], 64'hA0);

        // ---- Reset mid-frame with HR full ----
        clear_mon();
        send(32'hA5A5_A5A5, 1'b1, ka);
        send(32'hDEAD_BEEF, 1'b0, kb);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);   // cyc == ka + 13: bit 13 on the wire
        check("rst_bit13", {62'd0, serial_out, in_ready}, 64'b10);
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", {59'd0, out_valid, frame_start, serial_out, sign_ctrl, in_ready},
              64'b00001);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        check("rst_no_residual_valid", valid_cnt, 0);
        check("rst_no_hr_output", rx_data.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
